// File: rtl/channel_sweep_ctrl_pkg.sv
// Shared types and constants for the channel level-sweep sequencer.
package channel_sweep_ctrl_pkg;

  localparam int SAMPLE_WIDTH    = 12;
  localparam int NOISE_MAG_WIDTH = 8;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  localparam sample_t SAT_POS = sample_t'(12'h7FF);
  localparam sample_t SAT_NEG = sample_t'(12'h800);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT,
    ST_DONE
  } sweep_state_t;

  function automatic logic is_sat(input sample_t s);
    return (s == SAT_POS) || (s == SAT_NEG);
  endfunction

endpackage

// File: rtl/channel_sweep_ctrl_if.sv
// Statistics record handshake between the sweep sequencer and its consumer.
interface channel_sweep_ctrl_if
  import channel_sweep_ctrl_pkg::*;
#(
  parameter int NUM_LEVELS        = 8,
  parameter int SAMPLES_PER_LEVEL = 1024
);
  localparam int LW = $clog2(NUM_LEVELS);
  localparam int CW = $clog2(SAMPLES_PER_LEVEL + 1);

  logic                       stat_valid;
  logic                       stat_ready;
  logic [LW-1:0]              stat_level;
  logic [NOISE_MAG_WIDTH-1:0] stat_mag;
  sample_t                    stat_i_min;
  sample_t                    stat_i_max;
  sample_t                    stat_q_min;
  sample_t                    stat_q_max;
  logic [CW-1:0]              stat_sat_cnt;

  modport master (
    output stat_valid, stat_level, stat_mag,
    output stat_i_min, stat_i_max, stat_q_min, stat_q_max, stat_sat_cnt,
    input  stat_ready
  );

  modport slave (
    input  stat_valid, stat_level, stat_mag,
    input  stat_i_min, stat_i_max, stat_q_min, stat_q_max, stat_sat_cnt,
    output stat_ready
  );

endinterface

// File: rtl/channel_sweep_ctrl_iq_stat_accum.sv
// Running I/Q min/max and saturated-sample count for one measurement window.
module iq_stat_accum
  import channel_sweep_ctrl_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             valid_i,
  input  sample_t          i_i,
  input  sample_t          q_i,
  output sample_t          i_min_o,
  output sample_t          i_max_o,
  output sample_t          q_min_o,
  output sample_t          q_max_o,
  output logic [CNT_W-1:0] sat_cnt_o
);

  sample_t          i_min_q, i_max_q, q_min_q, q_max_q;
  logic [CNT_W-1:0] sat_cnt_q;

  // Extremes start inverted so the first sample always replaces both bounds.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      i_min_q   <= SAT_POS;
      i_max_q   <= SAT_NEG;
      q_min_q   <= SAT_POS;
      q_max_q   <= SAT_NEG;
      sat_cnt_q <= '0;
    end else if (valid_i) begin
      if (i_i < i_min_q) i_min_q <= i_i;
      if (i_i > i_max_q) i_max_q <= i_i;
      if (q_i < q_min_q) q_min_q <= q_i;
      if (q_i > q_max_q) q_max_q <= q_i;
      if (is_sat(i_i) || is_sat(q_i)) sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end
  end

  assign i_min_o   = i_min_q;
  assign i_max_o   = i_max_q;
  assign q_min_o   = q_min_q;
  assign q_max_o   = q_max_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: rtl/channel_sweep_ctrl.sv
// Steps noise_magnitude through a level table, settles, measures rx stats and
// reports one record per level. SETTLE_CYCLES must be at least 1.
module channel_sweep_ctrl
  import channel_sweep_ctrl_pkg::*;
#(
  parameter int NUM_LEVELS        = 8,
  parameter int SAMPLES_PER_LEVEL = 1024,
  parameter int SETTLE_CYCLES     = 8,
  localparam int LW = $clog2(NUM_LEVELS),
  localparam int NW = LW + 1,
  localparam int CW = $clog2(SAMPLES_PER_LEVEL + 1),
  localparam int SW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [LW-1:0]              cfg_addr,
  input  logic [NOISE_MAG_WIDTH-1:0] cfg_data,
  input  logic [NW-1:0]              cfg_num_levels,
  input  logic                       start,
  input  logic                       abort,
  input  sample_t                    rx_I,
  input  sample_t                    rx_Q,
  input  logic                       rx_valid,
  output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
  output logic                       chan_en,
  output logic                       busy,
  output logic                       done,
  channel_sweep_ctrl_if.master       stat
);

  sweep_state_t               state_q, state_d;
  logic [LW-1:0]              lvl_q, lvl_d;
  logic [NW-1:0]              n_q, n_d;
  logic [SW-1:0]              settle_q, settle_d;
  logic [CW-1:0]              smp_q, smp_d;
  logic [NOISE_MAG_WIDTH-1:0] mag_q, mag_d;
  logic [NOISE_MAG_WIDTH-1:0] tbl_q [NUM_LEVELS];
  logic                       acc_clr;
  sample_t                    acc_i_min, acc_i_max, acc_q_min, acc_q_max;
  logic [CW-1:0]              acc_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lvl_q    <= '0;
      n_q      <= '0;
      settle_q <= '0;
      smp_q    <= '0;
      mag_q    <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      n_q      <= n_d;
      settle_q <= settle_d;
      smp_q    <= smp_d;
      mag_q    <= mag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_LEVELS; k++) tbl_q[k] <= '0;
    end else if (cfg_we && state_q == ST_IDLE) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    n_d      = n_q;
    settle_d = settle_q;
    smp_d    = smp_q;
    mag_d    = mag_q;
    acc_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          lvl_d   = '0;
          if (cfg_num_levels == '0)                   n_d = NW'(1);
          else if (cfg_num_levels > NW'(NUM_LEVELS))  n_d = NW'(NUM_LEVELS);
          else                                        n_d = cfg_num_levels;
        end
      end
      ST_LOAD: begin
        mag_d    = tbl_q[lvl_q];
        acc_clr  = 1'b1;
        settle_d = SW'(SETTLE_CYCLES - 1);
        smp_d    = CW'(SAMPLES_PER_LEVEL - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d  = ST_MEASURE;
        else                settle_d = settle_q - SW'(1);
      end
      ST_MEASURE: begin
        if (rx_valid) begin
          if (smp_q == '0) state_d = ST_REPORT;
          else             smp_d   = smp_q - CW'(1);
        end
      end
      ST_REPORT: begin
        if (stat.stat_ready) begin
          if ({1'b0, lvl_q} == n_q - NW'(1)) begin
            state_d = ST_DONE;
          end else begin
            lvl_d   = lvl_q + LW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        mag_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      mag_d   = '0;
    end
  end

  iq_stat_accum #(.CNT_W(CW)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (acc_clr),
    .valid_i   (rx_valid && state_q == ST_MEASURE),
    .i_i       (rx_I),
    .q_i       (rx_Q),
    .i_min_o   (acc_i_min),
    .i_max_o   (acc_i_max),
    .q_min_o   (acc_q_min),
    .q_max_o   (acc_q_max),
    .sat_cnt_o (acc_sat)
  );

  assign noise_magnitude = mag_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign chan_en         = (state_q == ST_LOAD) || (state_q == ST_SETTLE) ||
                           (state_q == ST_MEASURE) || (state_q == ST_REPORT);

  // Accumulator is frozen outside MEASURE, so its registers are the payload;
  // masking keeps the record at zero whenever it is not being offered.
  assign stat.stat_valid   = (state_q == ST_REPORT);
  assign stat.stat_level   = stat.stat_valid ? lvl_q     : '0;
  assign stat.stat_mag     = stat.stat_valid ? mag_q     : '0;
  assign stat.stat_i_min   = stat.stat_valid ? acc_i_min : '0;
  assign stat.stat_i_max   = stat.stat_valid ? acc_i_max : '0;
  assign stat.stat_q_min   = stat.stat_valid ? acc_q_min : '0;
  assign stat.stat_q_max   = stat.stat_valid ? acc_q_max : '0;
  assign stat.stat_sat_cnt = stat.stat_valid ? acc_sat   : '0;

endmodule
